// File: rtl/pipe_trace_pkg.sv
// Shared types and entry layout for the pipeline trace buffer.
package pipe_trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRETRIG,
        ST_POSTTRIG,
        ST_DONE,
        ST_READOUT
    } state_t;

    localparam int CH_IF  = 0;
    localparam int CH_ID  = 1;
    localparam int CH_EX  = 2;
    localparam int CH_MEM = 3;

    // Entry layout, LSB first: channel payloads, channel valids, cycle stamp.
    function automatic int data_lsb();
        return 0;
    endfunction

    function automatic int valid_lsb(input int num_ch, input int ch_w);
        return num_ch * ch_w;
    endfunction

    function automatic int stamp_lsb(input int num_ch, input int ch_w);
        return num_ch * ch_w + num_ch;
    endfunction

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// Trace storage: simple dual-port RAM, one write and one registered read per cycle.
// Read data appears the cycle after re; it holds while re is low so it can act as a stall stage.
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int EW    = 84
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pipe_trace_buffer.sv
// Pipeline trace capture with pre/post trigger window; samples stored on the edge presented.
// Readout: 2 cycles from rd_start to first rd_valid, then one entry per cycle under rd_ready.
module pipe_trace_buffer
    import pipe_trace_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 16,
    parameter int DEPTH   = 64,
    parameter int STAMP_W = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int EW      = STAMP_W + NUM_CH + NUM_CH * CH_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_CH*CH_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]      ch_valid,
    input  logic                   arm,
    input  logic                   trig_in,
    input  logic [AW-1:0]          post_count,
    input  logic                   rd_start,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [EW-1:0]          rd_data,
    output logic [AW:0]            fill_count,
    output logic                   triggered,
    output logic                   done,
    output logic                   busy
);

    localparam int            DATA_LSB  = data_lsb();
    localparam int            VLD_LSB   = valid_lsb(NUM_CH, CH_W);
    localparam int            STAMP_LSB = stamp_lsb(NUM_CH, CH_W);
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_MAX  = AW'(DEPTH - 1);

    state_t             state;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      post_left;
    logic [AW:0]        rd_left;
    logic [STAMP_W-1:0] stamp;
    logic               q_vld;
    logic [EW-1:0]      q;
    logic [EW-1:0]      wdata;
    logic               we;
    logic               re;
    logic               out_take;
    logic               restart;

    always_comb begin
        wdata = '0;
        wdata[DATA_LSB  +: NUM_CH*CH_W] = ch_data;
        wdata[VLD_LSB   +: NUM_CH]      = ch_valid;
        wdata[STAMP_LSB +: STAMP_W]     = stamp;
    end

    assign restart  = arm && (state != ST_READOUT);
    assign we       = (state == ST_PRETRIG || state == ST_POSTTRIG) && !restart;
    assign out_take = !rd_valid || rd_ready;
    // Prefetch into the RAM output stage whenever it is empty or draining this cycle.
    assign re       = (state == ST_READOUT) && (rd_left != '0) && (!q_vld || out_take);
    assign done     = (state == ST_DONE);
    assign busy     = (state != ST_IDLE);

    trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .EW    (EW)
    ) u_ram (
        .clock (clock),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (wdata),
        .re    (re),
        .raddr (rd_ptr),
        .rdata (q)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            post_left  <= '0;
            rd_left    <= '0;
            fill_count <= '0;
            triggered  <= 1'b0;
            stamp      <= '0;
            q_vld      <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            stamp <= stamp + 1'b1;
            if (restart) begin
                state      <= ST_PRETRIG;
                wr_ptr     <= '0;
                fill_count <= '0;
                triggered  <= 1'b0;
                post_left  <= (post_count > POST_MAX) ? POST_MAX : post_count;
            end else begin
                case (state)
                    ST_PRETRIG, ST_POSTTRIG: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (fill_count != FULL) fill_count <= fill_count + 1'b1;
                        if (state == ST_PRETRIG) begin
                            if (trig_in) begin
                                triggered <= 1'b1;
                                state     <= (post_left == '0) ? ST_DONE : ST_POSTTRIG;
                            end
                        end else begin
                            post_left <= post_left - 1'b1;
                            if (post_left == AW'(1)) state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (rd_start) begin
                            state   <= ST_READOUT;
                            rd_ptr  <= wr_ptr - fill_count[AW-1:0];
                            rd_left <= fill_count;
                        end
                    end
                    ST_READOUT: begin
                        if (re) begin
                            rd_ptr  <= rd_ptr + 1'b1;
                            rd_left <= rd_left - 1'b1;
                        end
                        if (rd_valid && rd_ready && !q_vld && rd_left == '0) begin
                            state      <= ST_IDLE;
                            fill_count <= '0;
                            triggered  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            if (re)            q_vld <= 1'b1;
            else if (out_take) q_vld <= 1'b0;

            if (out_take) begin
                rd_valid <= q_vld;
                if (q_vld) rd_data <= q;
            end
        end
    end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Bench for pipe_trace_buffer: scenario table plus randomized captures against a queue model.
module tb_pipe_trace_buffer;
    import pipe_trace_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = 16;
    localparam int DEPTH   = 8;
    localparam int STAMP_W = 16;
    localparam int AW      = 3;
    localparam int EW      = STAMP_W + NUM_CH + NUM_CH * CH_W;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [NUM_CH*CH_W-1:0] ch_data = '0;
    logic [NUM_CH-1:0]      ch_valid = '0;
    logic                   arm = 1'b0;
    logic                   trig_in = 1'b0;
    logic [AW-1:0]          post_count = '0;
    logic                   rd_start = 1'b0;
    logic                   rd_ready = 1'b0;
    logic                   rd_valid;
    logic [EW-1:0]          rd_data;
    logic [AW:0]            fill_count;
    logic                   triggered;
    logic                   done;
    logic                   busy;

    always #5 clock = ~clock;

    pipe_trace_buffer #(
        .NUM_CH (NUM_CH), .CH_W (CH_W), .DEPTH (DEPTH), .STAMP_W (STAMP_W)
    ) dut (
        .clock (clock), .reset (reset), .ch_data (ch_data), .ch_valid (ch_valid),
        .arm (arm), .trig_in (trig_in), .post_count (post_count), .rd_start (rd_start),
        .rd_ready (rd_ready), .rd_valid (rd_valid), .rd_data (rd_data),
        .fill_count (fill_count), .triggered (triggered), .done (done), .busy (busy)
    );

    int checks = 0;
    int failures = 0;

    // Free-running cycle stamp as seen by the capture logic: zero under reset, +1 per edge.
    logic [STAMP_W-1:0] tb_stamp = '0;
    always @(posedge clock) tb_stamp <= !reset ? '0 : tb_stamp + 1'b1;

    logic [EW-1:0]      exp_q[$];
    logic [STAMP_W-1:0] trig_stamp;

    typedef struct {
        int pre;
        int post;
        int mode;
        int arm_at;
        bit rds_pre;
        int exp_fill;
        int exp_trig;
    } vec_t;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive_sample(input bit rnd);
        if (rnd) begin
            ch_data  = {$urandom, $urandom};
            ch_valid = 4'($urandom);
        end else begin
            ch_data[CH_IF*CH_W  +: CH_W] = tb_stamp;
            ch_data[CH_ID*CH_W  +: CH_W] = tb_stamp;
            ch_data[CH_EX*CH_W  +: CH_W] = tb_stamp;
            ch_data[CH_MEM*CH_W +: CH_W] = tb_stamp;
            ch_valid = '1;
        end
    endtask

    // The buffer keeps only the newest DEPTH samples of a capture.
    task automatic record();
        exp_q.push_back({tb_stamp, ch_valid, ch_data});
        if (exp_q.size() > DEPTH) exp_q.delete(0);
    endtask

    task automatic capture(input int pre, input int post, input bit rnd, input bit rds_pre);
        int post_eff;
        arm = 1'b1;
        post_count = AW'(post);
        tick();
        arm = 1'b0;
        check("arm_busy", busy, 1);
        check("arm_done", done, 0);
        exp_q.delete();
        for (int i = 0; i < pre; i++) begin
            drive_sample(rnd);
            trig_in  = 1'b0;
            rd_start = rds_pre && (i == 0);
            record();
            tick();
        end
        rd_start = 1'b0;
        drive_sample(rnd);
        trig_in = 1'b1;
        trig_stamp = tb_stamp;
        record();
        tick();
        post_eff = (post > DEPTH - 1) ? DEPTH - 1 : post;
        for (int i = 0; i < post_eff; i++) begin
            drive_sample(rnd);
            trig_in = 1'($urandom_range(0, 1));
            record();
            tick();
        end
        trig_in = 1'b0;
        check("cap_done", done, 1);
        check("cap_busy", busy, 1);
        check("cap_triggered", triggered, 1);
        check("cap_fill", fill_count, exp_q.size());
        check("cap_no_rd_valid", rd_valid, 0);
    endtask

    // mode 0: ready held high; 1: ready pattern 1,0,0; 2: random ready.
    task automatic readout(input int mode, input int arm_at, input int trig_pos);
        int n, idx, cyc, first;
        n = exp_q.size();
        idx = 0;
        cyc = 0;
        first = -1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        while (idx < n && cyc < 400) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (cyc % 3 == 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            arm = (cyc == arm_at);
            if (rd_valid) begin
                if (first < 0) first = cyc;
                check($sformatf("rd_data[%0d]", idx), rd_data, exp_q[idx]);
                if (rd_ready && trig_pos == idx + 1)
                    check("trig_entry_stamp", rd_data[EW-1 -: STAMP_W], trig_stamp);
                if (rd_ready) idx++;
            end
            tick();
            cyc++;
        end
        arm = 1'b0;
        rd_ready = 1'b0;
        check("rd_all_transferred", idx, n);
        check("first_valid_latency", first, 2);
        if (mode == 0) check("no_bubble_cycles", cyc, n + 2);
        check("end_rd_valid", rd_valid, 0);
        check("end_done", done, 0);
        check("end_busy", busy, 0);
        check("end_fill", fill_count, 0);
        check("end_triggered", triggered, 0);
    endtask

    initial begin
        vec_t tbl[7];
        tbl[0] = '{3,  2, 0, -1, 1'b0, 6, 4};
        tbl[1] = '{20, 3, 0, -1, 1'b0, 8, 5};
        tbl[2] = '{1,  7, 0, -1, 1'b0, 8, 1};
        tbl[3] = '{4,  3, 1, -1, 1'b0, 8, 5};
        tbl[4] = '{2,  2, 0, -1, 1'b1, 5, 3};
        tbl[5] = '{6,  1, 0,  3, 1'b0, 8, 7};
        tbl[6] = '{0,  0, 0, -1, 1'b0, 1, 1};

        @(negedge clock);
        tick();
        tick();
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_fill", fill_count, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        tick();

        for (int r = 0; r < 7; r++) begin
            capture(tbl[r].pre, tbl[r].post, 1'b0, tbl[r].rds_pre);
            check($sformatf("tbl%0d_fill", r), fill_count, tbl[r].exp_fill);
            readout(tbl[r].mode, tbl[r].arm_at, tbl[r].exp_trig);
            tick();
        end

        // Reset in the middle of the post-trigger window.
        arm = 1'b1;
        post_count = AW'(5);
        tick();
        arm = 1'b0;
        tick();
        tick();
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_rd_data", rd_data, 0);
        check("midrst_fill", fill_count, 0);
        check("midrst_triggered", triggered, 0);
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        tick();

        for (int r = 0; r < 25; r++) begin
            capture(int'($urandom_range(0, 20)), int'($urandom_range(0, 7)), 1'b1, 1'b0);
            readout(int'($urandom_range(0, 2)), -1, 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_trace_buffer.md
# pipe_trace_buffer

On-chip trace capture for the pipelined CPU. It samples NUM_CH pipeline-stage channels every clock into a circular buffer. Capture can be armed, stopped by a trigger with programmable pre/post depth, and replayed oldest-first over a valid/ready stream. It sits beside the CPU, is fed from the IF/ID, ID/EX, EX/MEM and MEM/WB buffer contents, and gives hardware and benches a cycle-accurate pipeline history without a simulator-side display dump.

## Interface
- NUM_CH, 4: number of traced channels (pipeline stages)
- CH_W, 16: width of each channel's data
- DEPTH, 64: buffer entries; power of two, at least 4
- STAMP_W, 16: cycle-stamp width
- AW, log2(DEPTH): address/count width (derived)
- EW, STAMP_W+NUM_CH+NUM_CH*CH_W: entry width (derived)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- ch_data  in  NUM_CH*CH_W  channel payloads; channel k at bits [k*CH_W +: CH_W]
- ch_valid  in  NUM_CH  per-channel valid (stage not flushed/bubble)
- arm  in  1  single-cycle pulse; start capture
- trig_in  in  1  trigger condition (level, sampled)
- post_count  in  AW  samples to keep after the trigger sample; latched at arm
- rd_start  in  1  pulse; begin readout (DONE only)
- rd_ready  in  1  consumer ready
- rd_valid  out  1  rd_data valid
- rd_data  out  EW  {stamp, ch_valid, ch_data}
- fill_count  out  AW+1  entries currently held (0..DEPTH)
- triggered  out  1  trigger seen in this capture
- done  out  1  capture complete, awaiting readout
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, PRETRIG, POSTTRIG, DONE, READOUT.
- IDLE: no capture. On arm → PRETRIG; wr_ptr=0, fill_count=0, post_count latched as post_left.
- PRETRIG: on every edge, write {stamp, ch_valid, ch_data} at wr_ptr and increment wr_ptr (wraps mod DEPTH). fill_count saturates at DEPTH; once full, the oldest entry is overwritten. If trig_in=1 on an edge, that sample is written as the trigger sample and triggered=1. Then → POSTTRIG, or → DONE if post_left=0.
- POSTTRIG: write each edge and decrement post_left; the edge that writes the last post sample → DONE. trig_in is ignored.
- post_count ≥ DEPTH-1 is clamped to DEPTH-1 so the trigger sample is never overwritten.
- DONE: no writes. rd_start → READOUT, with rd_ptr = oldest entry = (wr_ptr - fill_count) mod DEPTH.
- READOUT: stream fill_count entries oldest-first. An entry transfers on rd_valid&rd_ready. After the last transfer → IDLE; fill_count and triggered clear on entry to IDLE.
- arm in PRETRIG/POSTTRIG/DONE restarts capture as from IDLE. arm in READOUT is ignored. rd_start outside DONE is ignored.
- Stamp: free-running counter, +1 every cycle, wraps 2^STAMP_W-1 → 0. It is never stalled.
- Reset mid-operation: → IDLE, pointers and counts cleared. Memory contents are undefined afterwards and are never read before being rewritten.

## Timing
- Reset values: rd_valid=0, rd_data=0, fill_count=0, triggered=0, done=0, busy=0, stamp=0.
- Capture latency: a sample is stored at the edge where it is presented. The first stored sample is the edge after the arm edge.
- done=1 exactly while in DONE. busy=1 in all states except IDLE.
- Readout:
  - Synchronous-read RAM feeding a one-entry output register.
  - First rd_valid is 2 cycles after the rd_start edge.
  - With rd_ready held high, one entry transfers per cycle, no bubbles (prefetch).
  - rd_data is stable while rd_valid&!rd_ready.
  - rd_valid drops the cycle after the last transfer.
- trig_in and arm on the same edge in IDLE: arm wins. The trigger is not sampled until PRETRIG.

## Structure
- Shared package pipe_trace_pkg:
  - state enum
  - entry field offsets
  - channel index constants (CH_IF=0, CH_ID=1, CH_EX=2, CH_MEM=3)
- Sub-module trace_ram: simple dual-port, 1 write / 1 synchronous read, DEPTH x EW.
- FSM, pointers, stamp and output register live in the top module.

## Test plan
Defaults: NUM_CH=4, CH_W=16, DEPTH=8; ch_data is the stamp replicated into every channel.
- Basic capture: arm, 3 idle cycles, trig_in at the 4th edge, post_count=2 → done. fill_count=6. Readout yields stamps s+1..s+6, with the trigger at the 4th entry and triggered=1.
- Wrap: arm, 20 cycles before trigger, post_count=3 → fill_count=8. Readout is the last 8 stamps, oldest first; trigger entry is the 5th.
- Clamp: post_count=7, trigger on the 2nd edge → 8 entries. The trigger sample is first; no overwrite of the trigger entry.
- Backpressure: rd_ready toggles 1,0,0,1… → each entry is transferred exactly once, in order. rd_data is held during stalls; done returns to 0 after the last entry.
- Reset mid-POSTTRIG: reset=0 for 1 cycle → all outputs at reset values, busy=0. A subsequent arm/trigger works normally.
- Ignored events: rd_start in PRETRIG → no rd_valid. arm during READOUT → stream continues unchanged.
